// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Holds the serializer state encoding, register offsets and STATUS bit layout.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_BAUD   = 2'd2;

   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_BUSY  = 2;
   localparam int ST_OVF   = 3;

   // Packs the four status flags into the word the core sees on a STATUS load.
   function automatic logic [31:0] statusWord(input logic full,
                                              input logic empty,
                                              input logic busy,
                                              input logic ovf);
      logic [31:0] w;
      w           = '0;
      w[ST_FULL]  = full;
      w[ST_EMPTY] = empty;
      w[ST_BUSY]  = busy;
      w[ST_OVF]   = ovf;
      return w;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO for the UART transmit path; head data is visible combinationally.
// Push when full and pop when empty are ignored.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q;
   logic [AW-1:0]    rdPtr_q;
   logic [AW:0]      count_q;
   logic             doPush;
   logic             doPop;

   assign full_o  = (count_q == CNT_MAX);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rdPtr_q];
   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && !empty_o;

   // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + PTR_ONE;
         if (doPop)  rdPtr_q <= rdPtr_q + PTR_ONE;
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= data_i;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the single-cycle core's data bus.
// Stores fill a TX FIFO; loads return STATUS/BAUDDIV combinationally in the same cycle.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
   parameter int          FIFO_DEPTH   = 8,
   parameter int          CLKS_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Hit,
   output logic        tx,
   output logic        busy
);

   localparam int          CW         = $clog2(FIFO_DEPTH);
   localparam logic [15:0] BAUD_RESET = 16'(CLKS_PER_BIT - 1);
   localparam logic [CW:0] CNT_FULL   = (CW+1)'(FIFO_DEPTH);

   logic [1:0]  offset;
   logic        wrEn;
   logic        txdataWr;
   logic        ovfSet;
   logic        ovfClr;
   logic        baudWr;

   logic        fifoPush;
   logic        fifoPop;
   logic [7:0]  fifoHead;
   logic        fifoFull;
   logic        fifoEmpty;
   logic [CW:0] fifoCount;
   logic        statusFull;
   logic        statusEmpty;

   logic [15:0] baudDiv_q;
   logic [15:0] baudDiv_d;
   logic        ovf_q;
   logic        ovf_d;

   state_t      state_q;
   logic [7:0]  shift_q;
   logic [2:0]  bitCnt_q;
   logic [15:0] baudCnt_q;
   logic        tx_q;

   logic        unusedBusBits;

   // Byte lane bits of the address and the upper store bits carry no meaning here.
   assign unusedBusBits = ^{DataAdr[1:0], WriteData[31:16]};

   assign Hit      = (DataAdr[31:4] == BASE_ADDR[31:4]);
   assign offset   = DataAdr[3:2];
   assign wrEn     = MemWrite && Hit;
   assign txdataWr = wrEn && (offset == OFF_TXDATA);
   assign baudWr   = wrEn && (offset == OFF_BAUD);
   assign ovfClr   = wrEn && (offset == OFF_STATUS) && WriteData[ST_OVF];

   // Fullness is judged on the registered count, so a same-edge pop never makes room.
   assign fifoPush = txdataWr && !fifoFull;
   assign ovfSet   = txdataWr && fifoFull;

   assign statusFull  = (fifoCount == CNT_FULL);
   assign statusEmpty = (fifoCount == '0);

   assign busy = (state_q != IDLE);
   assign tx   = tx_q;

   uart_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) uFifo (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (fifoPush),
      .data_i  (WriteData[7:0]),
      .pop_i   (fifoPop),
      .data_o  (fifoHead),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .count_o (fifoCount)
   );

   always_comb begin
      ReadData = '0;
      if (Hit) begin
         case (offset)
            OFF_STATUS: ReadData = statusWord(statusFull, statusEmpty, busy, ovf_q);
            OFF_BAUD:   ReadData = {16'h0000, baudDiv_q};
            default:    ReadData = '0;
         endcase
      end
   end

   // Clear is applied before set so an overflow on the same edge keeps ovf high.
   always_comb begin
      baudDiv_d = baudDiv_q;
      ovf_d     = ovf_q;
      if (baudWr) baudDiv_d = WriteData[15:0];
      if (ovfClr) ovf_d = 1'b0;
      if (ovfSet) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         baudDiv_q <= BAUD_RESET;
         ovf_q     <= 1'b0;
      end else begin
         baudDiv_q <= baudDiv_d;
         ovf_q     <= ovf_d;
      end
   end

   // A new frame starts from IDLE, or straight out of an expiring STOP bit.
   always_comb begin
      fifoPop = 1'b0;
      if (!fifoEmpty) begin
         if (state_q == IDLE)
            fifoPop = 1'b1;
         else if ((state_q == STOP) && (baudCnt_q == '0))
            fifoPop = 1'b1;
      end
   end

   // Each bit lasts baudCnt_q+1 cycles; the bit period is reloaded only at a bit boundary.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bitCnt_q  <= '0;
         baudCnt_q <= '0;
         tx_q      <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               tx_q <= 1'b1;
               if (fifoPop) begin
                  shift_q   <= fifoHead;
                  baudCnt_q <= baudDiv_q;
                  tx_q      <= 1'b0;
                  state_q   <= START;
               end
            end
            START: begin
               if (baudCnt_q == '0) begin
                  state_q   <= DATA;
                  bitCnt_q  <= '0;
                  baudCnt_q <= baudDiv_q;
                  tx_q      <= shift_q[0];
               end else begin
                  baudCnt_q <= baudCnt_q - 16'd1;
               end
            end
            DATA: begin
               if (baudCnt_q == '0) begin
                  baudCnt_q <= baudDiv_q;
                  if (bitCnt_q == 3'd7) begin
                     state_q <= STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     shift_q  <= {1'b0, shift_q[7:1]};
                     tx_q     <= shift_q[1];
                     bitCnt_q <= bitCnt_q + 3'd1;
                  end
               end else begin
                  baudCnt_q <= baudCnt_q - 16'd1;
               end
            end
            STOP: begin
               if (baudCnt_q == '0) begin
                  if (fifoPop) begin
                     shift_q   <= fifoHead;
                     baudCnt_q <= baudDiv_q;
                     tx_q      <= 1'b0;
                     state_q   <= START;
                  end else begin
                     tx_q    <= 1'b1;
                     state_q <= IDLE;
                  end
               end else begin
                  baudCnt_q <= baudCnt_q - 16'd1;
               end
            end
            default: begin
               tx_q    <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a frame-level reference model is compared
// against tx/busy/Hit/ReadData every cycle, plus hand-computed literal scenarios.
module tb_mmio_uart_tx;

   logic        clk;
   logic        reset;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Hit;
   logic        tx;
   logic        busy;

   int total;
   int bad;

   logic [7:0]  mq [$];
   logic        mOvf;
   logic [15:0] mBaud;
   logic        mBusy;
   int          mBit;
   int          mRemain;
   logic [7:0]  mByte;

   mmio_uart_tx dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .DataAdr   (DataAdr),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .Hit       (Hit),
      .tx        (tx),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: FIFO as a queue, frame as position 0..9 (start, d0..d7, stop).
   task automatic modelReset();
      mq.delete();
      mOvf    = 1'b0;
      mBaud   = 16'd15;
      mBusy   = 1'b0;
      mBit    = 0;
      mRemain = 0;
      mByte   = 8'h00;
   endtask

   task automatic modelStartFrame();
      mByte   = mq.pop_front();
      mBit    = 0;
      mRemain = int'(mBaud);
      mBusy   = 1'b1;
   endtask

   function automatic logic inWindow(input logic [31:0] adr);
      return adr[31:4] == 28'h000_0040;
   endfunction

   task automatic modelStep();
      logic       wr;
      logic [1:0] off;
      logic       wasFull;
      wr      = MemWrite && inWindow(DataAdr);
      off     = DataAdr[3:2];
      wasFull = (mq.size() == 8);
      if (!mBusy) begin
         if (mq.size() > 0) modelStartFrame();
      end else if (mRemain > 0) begin
         mRemain--;
      end else if (mBit < 9) begin
         mBit++;
         mRemain = int'(mBaud);
      end else if (mq.size() > 0) begin
         modelStartFrame();
      end else begin
         mBusy = 1'b0;
      end
      if (wr && off == 2'd0) begin
         if (wasFull) mOvf = 1'b1;
         else mq.push_back(WriteData[7:0]);
      end
      if (wr && off == 2'd1 && WriteData[3]) mOvf = 1'b0;
      if (wr && off == 2'd2) mBaud = WriteData[15:0];
   endtask

   function automatic logic modelTx();
      if (!mBusy) return 1'b1;
      if (mBit == 0) return 1'b0;
      if (mBit == 9) return 1'b1;
      return mByte[mBit-1];
   endfunction

   function automatic logic [31:0] modelRead(input logic [31:0] adr);
      if (!inWindow(adr)) return 32'h0;
      case (adr[3:2])
         2'd1:    return {28'h0, mOvf, mBusy, mq.size() == 0, mq.size() == 8};
         2'd2:    return {16'h0, mBaud};
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (reset) modelStep();
   end

   always @(negedge clk) begin
      checkOutput("tx", 32'(tx), 32'(modelTx()));
      checkOutput("busy", 32'(busy), 32'(mBusy));
      checkOutput("hit", 32'(Hit), 32'(inWindow(DataAdr)));
      checkOutput("readData", ReadData, modelRead(DataAdr));
   end

   // Called at posedge+1; the access is sampled by the next posedge.
   task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] data);
      MemWrite  = we;
      DataAdr   = adr;
      WriteData = data;
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
   endtask

   task automatic readReg(input logic [31:0] adr, output logic [31:0] data, output logic hitv);
      MemWrite = 1'b0;
      DataAdr  = adr;
      #2;
      data = ReadData;
      hitv = Hit;
      @(posedge clk);
      #1;
   endtask

   task automatic waitIdle(input int maxCycles);
      logic done;
      done     = 1'b0;
      MemWrite = 1'b0;
      for (int c = 0; c < maxCycles; c++) begin
         if (!busy && mq.size() == 0) begin
            done = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      checkOutput("drainTimeout", 32'(done), 32'd1);
   endtask

   logic [31:0] rd;
   logic        hv;
   logic        txLog   [41];
   logic        busyLog [41];
   logic        levels  [10];
   int          cnt;
   int unsigned sel;
   logic [31:0] d;

   initial begin
      total     = 0;
      bad       = 0;
      MemWrite  = 1'b0;
      DataAdr   = 32'h0;
      WriteData = 32'h0;
      reset     = 1'b1;
      levels    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      #1;
      reset = 1'b0;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;

      readReg(32'h404, rd, hv);
      checkOutput("resetStatus", rd, 32'h2);
      readReg(32'h408, rd, hv);
      checkOutput("resetBaud", rd, 32'hF);

      readReg(32'h40C, rd, hv);
      checkOutput("reservedRead", rd, 32'h0);
      checkOutput("reservedHit", 32'(hv), 32'd1);
      readReg(32'h410, rd, hv);
      checkOutput("outsideRead", rd, 32'h0);
      checkOutput("outsideHit", 32'(hv), 32'd0);
      applyStimulus(1'b1, 32'h408, 32'hFFFF_0007);
      applyStimulus(1'b1, 32'h40C, 32'hFFFF_FFFF);
      readReg(32'h408, rd, hv);
      checkOutput("baudUpperMasked", rd, 32'h7);

      // 8'hA5 at BAUDDIV=3: four cycles per bit, LSB first.
      applyStimulus(1'b1, 32'h408, 32'h3);
      applyStimulus(1'b1, 32'h400, 32'hA5);
      for (int i = 0; i < 41; i++) begin
         @(posedge clk);
         #1;
         txLog[i]   = tx;
         busyLog[i] = busy;
      end
      checkOutput("a5Latency", 32'(txLog[0]), 32'd0);
      for (int k = 0; k < 10; k++)
         checkOutput($sformatf("a5Bit%0d", k), 32'(txLog[4*k+2]), 32'(levels[k]));
      checkOutput("a5BusyLast", 32'(busyLog[39]), 32'd1);
      checkOutput("a5BusyFall", 32'(busyLog[40]), 32'd0);

      // Two queued bytes run back to back: 80 busy cycles with no gap.
      applyStimulus(1'b1, 32'h400, 32'h3C);
      applyStimulus(1'b1, 32'h400, 32'hC3);
      cnt = 0;
      for (int c = 0; c < 200; c++) begin
         if (busy) cnt++;
         else if (cnt > 0) break;
         @(posedge clk);
         #1;
      end
      checkOutput("backToBackLen", 32'(cnt), 32'd80);

      // Nine stores fit because the first one pops; the tenth overflows.
      applyStimulus(1'b1, 32'h408, 32'd15);
      for (int i = 0; i < 9; i++)
         applyStimulus(1'b1, 32'h400, 32'h10 + 32'(i));
      readReg(32'h404, rd, hv);
      checkOutput("fullNoOvf", rd, 32'h5);
      applyStimulus(1'b1, 32'h400, 32'hEE);
      readReg(32'h404, rd, hv);
      checkOutput("fullOvf", rd, 32'hD);
      applyStimulus(1'b1, 32'h404, 32'h8);
      readReg(32'h404, rd, hv);
      checkOutput("ovfCleared", 32'(rd[3]), 32'd0);
      waitIdle(2500);
      readReg(32'h404, rd, hv);
      checkOutput("drainedStatus", rd, 32'h2);

      // Reset in the middle of a frame with bytes still queued.
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 32'h400, 32'h5A + 32'(i));
      repeat (30) @(posedge clk);
      #3;
      reset = 1'b0;
      modelReset();
      #1;
      checkOutput("midResetTx", 32'(tx), 32'd1);
      checkOutput("midResetBusy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      readReg(32'h404, rd, hv);
      checkOutput("postResetStatus", rd, 32'h2);
      readReg(32'h408, rd, hv);
      checkOutput("postResetBaud", rd, 32'hF);

      // Random traffic with short bit periods, checked cycle by cycle against the model.
      for (int n = 0; n < 3000; n++) begin
         sel = $urandom_range(0, 9);
         d   = $urandom();
         case (sel)
            0, 1, 2: applyStimulus(1'b1, 32'h400 | 32'($urandom_range(0, 3)), d);
            3:       applyStimulus(1'b1, 32'h408, {d[31:16], 16'($urandom_range(0, 3))});
            4:       applyStimulus(1'b1, 32'h404, d);
            5:       applyStimulus(1'b1, ($urandom_range(0, 1) != 0) ? 32'h410 : 32'h3F8, d);
            6:       applyStimulus(1'b1, 32'h40C, d);
            default: applyStimulus(1'b0, 32'h3F0 + 32'($urandom_range(0, 47)), d);
         endcase
      end
      waitIdle(3000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
